// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: word width, next-PC select codes, FSM states.
package pc_sequencer_pkg;
    localparam int WORD_W = 32;

    typedef logic [1:0] sel_t;
    localparam sel_t SEL_SEQ  = 2'b00;
    localparam sel_t SEL_JUMP = 2'b01;
    localparam sel_t SEL_JM   = 2'b10;
    localparam sel_t SEL_BR   = 2'b11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_JM_REQ = 1'b1
    } state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// Control, memory-fetch and link bundle between the decoder/memory side (master) and the sequencer (slave).
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic              instr_valid;
    sel_t              sel;
    logic              jbrn;
    logic              link_en;
    logic [15:0]       imm;
    logic [25:0]       jaddr;
    logic [WORD_W-1:0] rs_val;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] pc;
    logic              stall;
    logic              mem_req;
    logic [WORD_W-1:0] mem_addr;
    logic              link_we;
    logic [WORD_W-1:0] link_data;
    logic              exc;

    modport master (
        output instr_valid, sel, jbrn, link_en, imm, jaddr, rs_val, mem_ack, mem_rdata,
        input  pc, stall, mem_req, mem_addr, link_we, link_data, exc
    );

    modport slave (
        input  instr_valid, sel, jbrn, link_en, imm, jaddr, rs_val, mem_ack, mem_rdata,
        output pc, stall, mem_req, mem_addr, link_we, link_data, exc
    );
endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Combinational next-PC candidates: sequential, branch, absolute jump and jm fetch address.
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] pc_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       jaddr_i,
    input  logic [WORD_W-1:0] rs_val_i,
    output logic [WORD_W-1:0] pc4_o,
    output logic [WORD_W-1:0] bt_o,
    output logic [WORD_W-1:0] jt_o,
    output logic [WORD_W-1:0] ma_o
);
    logic [WORD_W-1:0] imm_sext;

    assign imm_sext = {{(WORD_W-16){imm_i[15]}}, imm_i};
    assign pc4_o    = pc_i + 32'd4;
    assign bt_o     = pc4_o + {imm_sext[WORD_W-3:0], 2'b00};
    assign jt_o     = {pc4_o[31:28], jaddr_i, 2'b00};
    assign ma_o     = rs_val_i + imm_sext;
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with memory-indirect jump fetch FSM and link strobe.
// Optional macro PC_ALIGN_CHECK_EN traps misaligned non-sequential targets to EXC_VECTOR.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              mem_req_q, mem_req_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic              link_we_q, link_we_d;
    logic [WORD_W-1:0] link_data_q, link_data_d;
    logic              exc_q, exc_d;

    logic [WORD_W-1:0] pc4, bt, jt, ma;
    logic [WORD_W-1:0] target;
    logic              load;

    pc_target_calc u_calc (
        .pc_i     (pc_q),
        .imm_i    (bus.imm),
        .jaddr_i  (bus.jaddr),
        .rs_val_i (bus.rs_val),
        .pc4_o    (pc4),
        .bt_o     (bt),
        .jt_o     (jt),
        .ma_o     (ma)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        link_we_d   = 1'b0;
        link_data_d = link_data_q;
        exc_d       = 1'b0;
        target      = pc4;
        load        = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (bus.instr_valid) begin
                    if (bus.link_en) begin
                        link_we_d   = 1'b1;
                        link_data_d = pc4;
                    end
                    unique case (bus.sel)
                        SEL_SEQ:  begin target = pc4; load = 1'b1; end
                        SEL_BR:   begin target = bt;  load = 1'b1; end
                        SEL_JUMP: begin target = bus.jbrn ? bus.rs_val : jt; load = 1'b1; end
                        SEL_JM: begin
                            // pc holds until the fetched target word arrives
                            mem_addr_d = ma;
                            mem_req_d  = 1'b1;
                            state_d    = ST_JM_REQ;
                        end
                    endcase
                end
            end
            ST_JM_REQ: begin
                if (bus.mem_ack) begin
                    target    = bus.mem_rdata;
                    load      = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (load) begin
`ifdef PC_ALIGN_CHECK_EN
            // sequential loads are exempt; every other source is trapped when misaligned
            if (target[1:0] != 2'b00 && !(state_q == ST_RUN && bus.sel == SEL_SEQ)) begin
                pc_d  = EXC_VECTOR;
                exc_d = 1'b1;
            end else begin
                pc_d  = target;
            end
`else
            pc_d = {target[WORD_W-1:2], 2'b00};
`endif
        end
    end

`ifndef PC_ALIGN_CHECK_EN
    logic unused_align;
    assign unused_align = ^{EXC_VECTOR, target[1:0], exc_d};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
`ifdef PC_ALIGN_CHECK_EN
            exc_q       <= exc_d;
`else
            exc_q       <= 1'b0;
`endif
        end
    end

    assign bus.pc        = pc_q;
    assign bus.stall     = (state_q == ST_JM_REQ);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_data = link_data_q;
    assign bus.exc       = exc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential, branch, jump/link, jm fetch, reset abort, alignment.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // advance one rising edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input sel_t s, input logic jb, input logic ln,
                         input logic [15:0] im, input logic [25:0] ja, input logic [31:0] rs);
        bus.instr_valid = v;
        bus.sel         = s;
        bus.jbrn        = jb;
        bus.link_en     = ln;
        bus.imm         = im;
        bus.jaddr       = ja;
        bus.rs_val      = rs;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        drive(1'b0, SEL_SEQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);

        // reset state
        #12;
        chk("rst_pc",      bus.pc,        32'h0);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_stall",   {31'b0, bus.stall},   32'h0);
        chk("rst_link_we", {31'b0, bus.link_we}, 32'h0);
        chk("rst_exc",     {31'b0, bus.exc},     32'h0);
        chk("rst_maddr",   bus.mem_addr,  32'h0);

        // release away from the edge, then run sequentially
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, SEL_SEQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("seq_pc0", bus.pc, 32'h0);
        step(); chk("seq_pc4",  bus.pc, 32'h4);
        step(); chk("seq_pc8",  bus.pc, 32'h8);
        step(); chk("seq_pc12", bus.pc, 32'hC);

        // branch backward and forward from 0x100
        drive(1'b1, SEL_JUMP, 1'b1, 1'b0, 16'h0, 26'h0, 32'h100);
        step(); chk("set_pc100", bus.pc, 32'h100);
        drive(1'b1, SEL_BR, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0);
        step(); chk("br_back", bus.pc, 32'hFC);
        drive(1'b1, SEL_JUMP, 1'b1, 1'b0, 16'h0, 26'h0, 32'h100);
        step();
        drive(1'b1, SEL_BR, 1'b0, 1'b0, 16'h0003, 26'h0, 32'h0);
        step(); chk("br_fwd", bus.pc, 32'h110);

        // absolute jump with link
        drive(1'b1, SEL_JUMP, 1'b1, 1'b0, 16'h0, 26'h0, 32'h4000_0010);
        step(); chk("set_pc4000", bus.pc, 32'h4000_0010);
        drive(1'b1, SEL_JUMP, 1'b0, 1'b1, 16'h0, 26'h0000040, 32'h0);
        step();
        chk("jmp_pc",     bus.pc,        32'h4000_0100);
        chk("jmp_lwe",    {31'b0, bus.link_we}, 32'h1);
        chk("jmp_ldata",  bus.link_data, 32'h4000_0014);

        // idle: pc holds, link strobe clears
        drive(1'b0, SEL_SEQ, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        step();
        chk("idle_pc",  bus.pc, 32'h4000_0100);
        chk("idle_lwe", {31'b0, bus.link_we}, 32'h0);

        // memory-indirect jump, ack after 3 wait cycles
        drive(1'b1, SEL_JM, 1'b0, 1'b0, 16'h0008, 26'h0, 32'h200);
        step();
        chk("jm_req1",   {31'b0, bus.mem_req}, 32'h1);
        chk("jm_addr",   bus.mem_addr, 32'h208);
        chk("jm_stall1", {31'b0, bus.stall},   32'h1);
        chk("jm_pchold", bus.pc, 32'h4000_0100);
        // inputs during the fetch must be ignored
        drive(1'b1, SEL_BR, 1'b0, 1'b1, 16'h0010, 26'h0, 32'h999);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("jm_req_wait", {31'b0, bus.mem_req}, 32'h1);
            chk("jm_addr_wait", bus.mem_addr, 32'h208);
            chk("jm_pc_wait",  bus.pc, 32'h4000_0100);
            chk("jm_lwe_wait", {31'b0, bus.link_we}, 32'h0);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h3000;
        drive(1'b0, SEL_SEQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        bus.mem_ack = 1'b0;
        chk("jm_pc_done",  bus.pc, 32'h3000);
        chk("jm_req_done", {31'b0, bus.mem_req}, 32'h0);
        chk("jm_stall_done", {31'b0, bus.stall}, 32'h0);

        // misaligned fetched word is word-aligned without the trap
        drive(1'b1, SEL_JM, 1'b0, 1'b0, 16'h0, 26'h0, 32'h400);
        step();
        drive(1'b0, SEL_SEQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h3003;
        step();
        bus.mem_ack = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk("jm_misalign_pc",  bus.pc, 32'h80);
        chk("jm_misalign_exc", {31'b0, bus.exc}, 32'h1);
`else
        chk("jm_misalign_pc",  bus.pc, 32'h3000);
        chk("jm_misalign_exc", {31'b0, bus.exc}, 32'h0);
`endif

        // reset mid-fetch aborts immediately; stale ack ignored
        drive(1'b1, SEL_JM, 1'b0, 1'b0, 16'h0008, 26'h0, 32'h200);
        step();
        chk("abort_req_pre", {31'b0, bus.mem_req}, 32'h1);
        drive(1'b0, SEL_SEQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req",   {31'b0, bus.mem_req}, 32'h0);
        chk("abort_pc",    bus.pc, 32'h0);
        chk("abort_stall", {31'b0, bus.stall}, 32'h0);
        chk("abort_maddr", bus.mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5554;
        step();
        bus.mem_ack = 1'b0;
        chk("stale_ack_pc",  bus.pc, 32'h0);
        chk("stale_ack_req", {31'b0, bus.mem_req}, 32'h0);

        // misaligned register jump
        drive(1'b1, SEL_JUMP, 1'b1, 1'b1, 16'h0, 26'h0, 32'h102);
        step();
        chk("align_lwe", {31'b0, bus.link_we}, 32'h1);
`ifdef PC_ALIGN_CHECK_EN
        chk("align_pc",  bus.pc, 32'h80);
        chk("align_exc", {31'b0, bus.exc}, 32'h1);
`else
        chk("align_pc",  bus.pc, 32'h100);
        chk("align_exc", {31'b0, bus.exc}, 32'h0);
`endif
        drive(1'b0, SEL_SEQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        chk("align_exc_clr", {31'b0, bus.exc}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
